mem_arbiter: RTL

Two-requester memory controller that shares the single 16-bit byte-addressed memory port between instruction fetch and data access. It sequences read requests as aligned multi-word line fills (for cache refill) and data writes as single-word write-through. It arbitrates round-robin when both requesters ask in the same cycle. It sits between the I/D fetch/miss logic and the memory, and is the only driver of the memory's enable/wr/addr/data_in.

---
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 16-bit memory port between instruction line
// fills and data line fills / single-word write-through.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int BURST_LEN  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         if_req,
  input  logic [ADDR_WIDTH-1:0]        if_addr,
  output logic                         if_ack,
  output logic                         if_data_valid,
  output logic [15:0]                  if_data,
  output logic [$clog2(BURST_LEN)-1:0] if_word_idx,
  output logic                         if_done,
  input  logic                         dm_req,
  input  logic                         dm_wr,
  input  logic [ADDR_WIDTH-1:0]        dm_addr,
  input  logic [15:0]                  dm_wdata,
  output logic                         dm_ack,
  output logic                         dm_data_valid,
  output logic [15:0]                  dm_data,
  output logic [$clog2(BURST_LEN)-1:0] dm_word_idx,
  output logic                         dm_done,
  output logic                         mem_enable,
  output logic                         mem_wr,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [15:0]                  mem_data_in,
  input  logic [15:0]                  mem_data_out
);

  localparam int IDX_W = $clog2(BURST_LEN);
  localparam int OFFS_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, IFILL, DFILL, DWRITE} state_t;

  state_t                  state_q, state_d;
  logic                    last_dm_q;
  logic [IDX_W-1:0]        count_q;
  logic [ADDR_WIDTH-1:1]   addr_q;
  logic [15:0]             wdata_q;
  logic                    if_valid_q, if_done_q, dm_valid_q, dm_done_q;
  logic [15:0]             if_data_q, dm_data_q;
  logic [IDX_W-1:0]        if_idx_q, dm_idx_q;
  logic                    gnt_if, gnt_dm;
  logic                    unused_addr_lsb;

  // Byte-lane bit is never used: fills are line aligned, writes are word aligned.
  assign unused_addr_lsb = if_addr[0] ^ dm_addr[0];

  always_comb begin
    gnt_if  = 1'b0;
    gnt_dm  = 1'b0;
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (if_req && dm_req) begin
          gnt_if = last_dm_q;
          gnt_dm = !last_dm_q;
        end else begin
          gnt_if = if_req;
          gnt_dm = dm_req;
        end
        if (gnt_if)      state_d = IFILL;
        else if (gnt_dm) state_d = dm_wr ? DWRITE : DFILL;
      end
      IFILL, DFILL: if (count_q == LAST_IDX) state_d = IDLE;
      DWRITE:       state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  assign if_ack = gnt_if;
  assign dm_ack = gnt_dm;

  // Memory port decoded from registered state so reset drops it instantly.
  always_comb begin
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    unique case (state_q)
      IFILL, DFILL: begin
        mem_enable = 1'b1;
        mem_addr   = {addr_q[ADDR_WIDTH-1:OFFS_W], count_q, 1'b0};
      end
      DWRITE: begin
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = {addr_q, 1'b0};
        mem_data_in = wdata_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_dm_q  <= 1'b0;
      count_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_valid_q <= 1'b0;
      if_done_q  <= 1'b0;
      dm_valid_q <= 1'b0;
      dm_done_q  <= 1'b0;
      if_data_q  <= '0;
      dm_data_q  <= '0;
      if_idx_q   <= '0;
      dm_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      if_valid_q <= 1'b0;
      if_done_q  <= 1'b0;
      dm_valid_q <= 1'b0;
      dm_done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (gnt_if || gnt_dm) begin
            count_q   <= '0;
            last_dm_q <= gnt_dm;
            addr_q    <= gnt_dm ? dm_addr[ADDR_WIDTH-1:1] : if_addr[ADDR_WIDTH-1:1];
            if (gnt_dm) wdata_q <= dm_wdata;
          end
        end
        IFILL: begin
          if_data_q  <= mem_data_out;
          if_idx_q   <= count_q;
          if_valid_q <= 1'b1;
          if_done_q  <= (count_q == LAST_IDX);
          count_q    <= count_q + 1'b1;
        end
        DFILL: begin
          dm_data_q  <= mem_data_out;
          dm_idx_q   <= count_q;
          dm_valid_q <= 1'b1;
          dm_done_q  <= (count_q == LAST_IDX);
          count_q    <= count_q + 1'b1;
        end
        DWRITE:  dm_done_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign if_data_valid = if_valid_q;
  assign if_data       = if_data_q;
  assign if_word_idx   = if_idx_q;
  assign if_done       = if_done_q;
  assign dm_data_valid = dm_valid_q;
  assign dm_data       = dm_data_q;
  assign dm_word_idx   = dm_idx_q;
  assign dm_done       = dm_done_q;

endmodule
